// File: rtl/farm_road_timer.sv
// Farm-road side of the traffic-light pair: times each highway phase decoded from HW_LED,
// issues the time_out advance strobe and sequences the farm lamps during highway red.
module farm_road_timer #(
    parameter int unsigned HW_GREEN_MIN   = 8,
    parameter int unsigned HW_YELLOW_TIME = 3,
    parameter int unsigned FR_GREEN_TIME  = 5,
    parameter int unsigned FR_YELLOW_TIME = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic [2:0] HW_LED,
    output logic       time_out,
    output logic [2:0] FR_LED,
    output logic       phase_err
);

    typedef enum logic [1:0] {PH_HG, PH_HY, PH_HR, PH_ERR} phase_t;
    typedef enum logic [1:0] {FS_IDLE, FS_FG, FS_FY} farm_t;

    localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HW_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] HY_LAST = CNT_W'(HW_YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FR_GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] HR_LAST = CNT_W'(FR_GREEN_TIME + FR_YELLOW_TIME - 1);

    logic [2:0]       hw_prev;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt;
    logic             changed;
    phase_t           phase;
    farm_t            farm_q;
    farm_t            farm_cur;
    farm_t            farm_d;

    always_comb begin
        phase = PH_ERR;
        case (HW_LED)
            3'b100:  phase = PH_HG;
            3'b010:  phase = PH_HY;
            3'b001:  phase = PH_HR;
            default: phase = PH_ERR;
        endcase
    end

    // A change of HW_LED restarts timing in the same cycle, so the registered
    // count and farm state are overridden combinationally on the change cycle.
    assign changed = (HW_LED != hw_prev);
    assign cnt     = changed ? '0 : cnt_q;

    always_comb begin
        farm_cur = FS_IDLE;
        farm_d   = FS_IDLE;
        if (phase == PH_HR) begin
            farm_cur = (changed || farm_q == FS_IDLE) ? FS_FG : farm_q;
            case (farm_cur)
                FS_FG:   farm_d = (cnt == FG_LAST) ? FS_FY : FS_FG;
                FS_FY:   farm_d = FS_FY;
                default: farm_d = FS_IDLE;
            endcase
        end
    end

    always_comb begin
        time_out  = 1'b0;
        FR_LED    = 3'b001;
        phase_err = 1'b0;
        if (rst_n) begin
            case (phase)
                PH_HG: time_out = sensor && (cnt >= HG_LAST);
                PH_HY: time_out = (cnt == HY_LAST);
                PH_HR: begin
                    FR_LED   = (farm_cur == FS_FY) ? 3'b010 : 3'b100;
                    time_out = (farm_cur == FS_FY) && (cnt == HR_LAST);
                end
                default: phase_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_prev <= 3'b100;
            cnt_q   <= '0;
            farm_q  <= FS_IDLE;
        end else begin
            hw_prev <= HW_LED;
            cnt_q   <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
            farm_q  <= farm_d;
        end
    end

endmodule
